syn_lb_blk_decoder: RTL and testbench



---
 rtl/syn_lb_blk_decoder.sv | 158 +++++++++++++++
 tb/tb_syn_lb_blk_decoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/syn_lb_blk_decoder.sv
// Local-bus fan-out: blk1 selects one of NUM_CHLD children and {blk0, base} goes to it.
// Writes take one cycle; reads return child data, or DEFAULT_RD_DATA with lb_err when unmapped or timed out.
module syn_lb_blk_decoder #(
  parameter int LB_DATA_W  = 32,
  parameter int LB_BASE_W  = 8,
  parameter int LB_BLK_0_W = 4,
  parameter int LB_BLK_1_W = 4,
  parameter int LB_ADDR_W  = LB_BLK_1_W + LB_BLK_0_W + LB_BASE_W,
  parameter int NUM_CHLD   = 4,
  parameter int TIMEOUT    = 16,
  parameter logic [LB_DATA_W-1:0] DEFAULT_RD_DATA = 32'hDEADBEEF
) (
  input  logic                            clk_ir,
  input  logic                            rst_ih,
  input  logic                            lb_wr_en,
  input  logic                            lb_rd_en,
  input  logic [LB_ADDR_W-1:0]            lb_addr,
  input  logic [LB_DATA_W-1:0]            lb_wr_data,
  output logic                            lb_wr_valid,
  output logic                            lb_rd_valid,
  output logic [LB_DATA_W-1:0]            lb_rd_data,
  output logic                            lb_busy,
  output logic                            lb_err,
  output logic [NUM_CHLD-1:0]             chld_wr_en,
  output logic [NUM_CHLD-1:0]             chld_rd_en,
  output logic [LB_BLK_0_W+LB_BASE_W-1:0] chld_addr,
  output logic [LB_DATA_W-1:0]            chld_wr_data,
  input  logic [NUM_CHLD-1:0]             chld_rd_valid,
  input  logic [NUM_CHLD*LB_DATA_W-1:0]   chld_rd_data
);

  localparam int CA_W  = LB_BLK_0_W + LB_BASE_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [LB_BLK_1_W-1:0]   sel_q, sel_d;
  logic [CA_W-1:0]         addr_q, addr_d;
  logic [LB_DATA_W-1:0]    wdat_q, wdat_d;
  logic [LB_DATA_W-1:0]    rdat_q, rdat_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [LB_BLK_1_W-1:0]   req_blk;
  logic                    req_mapped;
  logic                    sel_mapped;
  logic                    sel_vld;
  logic [LB_DATA_W-1:0]    sel_dat;

  assign req_blk    = lb_addr[LB_ADDR_W-1 -: LB_BLK_1_W];
  assign req_mapped = {1'b0, req_blk} < (LB_BLK_1_W+1)'(NUM_CHLD);
  assign sel_mapped = {1'b0, sel_q} < (LB_BLK_1_W+1)'(NUM_CHLD);

  // Only the selected child's valid/data are observed; the rest are ignored.
  always_comb begin
    sel_vld = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NUM_CHLD; i++) begin
      if (sel_q == LB_BLK_1_W'(i)) begin
        sel_vld = chld_rd_valid[i];
        sel_dat = chld_rd_data[i*LB_DATA_W +: LB_DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (lb_wr_en) begin
          sel_d   = req_blk;
          addr_d  = lb_addr[CA_W-1:0];
          wdat_d  = lb_wr_data;
          state_d = WR;
        end else if (lb_rd_en) begin
          sel_d  = req_blk;
          addr_d = lb_addr[CA_W-1:0];
          cnt_d  = '0;
          if (req_mapped) begin
            err_d   = 1'b0;
            state_d = RD_WAIT;
          end else begin
            rdat_d  = DEFAULT_RD_DATA;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      WR: state_d = IDLE;
      RD_WAIT: begin
        // Data sampled in the last timeout cycle still beats the timeout.
        if (sel_vld) begin
          rdat_d  = sel_dat;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdat_d  = DEFAULT_RD_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_ir) begin
    if (rst_ih) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    chld_wr_en = '0;
    chld_rd_en = '0;
    for (int i = 0; i < NUM_CHLD; i++) begin
      if (sel_q == LB_BLK_1_W'(i)) begin
        chld_wr_en[i] = (state_q == WR);
        chld_rd_en[i] = (state_q == RD_WAIT) && (cnt_q == '0);
      end
    end
  end

  assign lb_wr_valid  = (state_q == WR);
  assign lb_rd_valid  = (state_q == RESP);
  assign lb_err       = ((state_q == WR) && !sel_mapped) || ((state_q == RESP) && err_q);
  assign lb_busy      = (state_q != IDLE);
  assign lb_rd_data   = rdat_q;
  assign chld_addr    = addr_q;
  assign chld_wr_data = wdat_q;

endmodule

// File: tb/tb_syn_lb_blk_decoder.sv
// Directed bench for syn_lb_blk_decoder with default parameters (4 children, TIMEOUT=16).
module tb_syn_lb_blk_decoder;

  logic         clk_ir = 1'b0;
  logic         rst_ih;
  logic         lb_wr_en, lb_rd_en;
  logic [15:0]  lb_addr;
  logic [31:0]  lb_wr_data;
  logic         lb_wr_valid, lb_rd_valid, lb_busy, lb_err;
  logic [31:0]  lb_rd_data;
  logic [3:0]   chld_wr_en, chld_rd_en;
  logic [11:0]  chld_addr;
  logic [31:0]  chld_wr_data;
  logic [3:0]   chld_rd_valid;
  logic [127:0] chld_rd_data;

  int total  = 0;
  int passed = 0;

  syn_lb_blk_decoder dut (
    .clk_ir        (clk_ir),
    .rst_ih        (rst_ih),
    .lb_wr_en      (lb_wr_en),
    .lb_rd_en      (lb_rd_en),
    .lb_addr       (lb_addr),
    .lb_wr_data    (lb_wr_data),
    .lb_wr_valid   (lb_wr_valid),
    .lb_rd_valid   (lb_rd_valid),
    .lb_rd_data    (lb_rd_data),
    .lb_busy       (lb_busy),
    .lb_err        (lb_err),
    .chld_wr_en    (chld_wr_en),
    .chld_rd_en    (chld_rd_en),
    .chld_addr     (chld_addr),
    .chld_wr_data  (chld_wr_data),
    .chld_rd_valid (chld_rd_valid),
    .chld_rd_data  (chld_rd_data)
  );

  always #5 clk_ir = ~clk_ir;

  // Advance one cycle; sample point sits 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk_ir);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst_ih        = 1'b1;
    lb_wr_en      = 1'b0;
    lb_rd_en      = 1'b0;
    lb_addr       = '0;
    lb_wr_data    = '0;
    chld_rd_valid = '0;
    chld_rd_data  = '0;
    cyc();
    cyc();
    chk("rst_busy", lb_busy, 0);
    chk("rst_outs", {lb_wr_valid, lb_rd_valid, lb_err, chld_wr_en, chld_rd_en}, 0);
    chk("rst_data", {chld_addr, chld_wr_data, lb_rd_data}, 0);
    rst_ih = 1'b0;
    cyc();

    // 1: write to child 2
    lb_wr_en = 1'b1; lb_addr = 16'h2345; lb_wr_data = 32'hA5A5_0001;
    cyc();
    lb_wr_en = 1'b0;
    chk("t1_wr_en",   chld_wr_en, 4'b0100);
    chk("t1_addr",    chld_addr, 12'h345);
    chk("t1_wdata",   chld_wr_data, 32'hA5A5_0001);
    chk("t1_wvalid",  lb_wr_valid, 1);
    chk("t1_err",     lb_err, 0);
    chk("t1_busy",    lb_busy, 1);
    cyc();
    chk("t1_idle",    {lb_busy, lb_wr_valid, chld_wr_en}, 0);

    // 2: read child 1, response at T3
    lb_rd_en = 1'b1; lb_addr = 16'h1010;
    cyc();
    lb_rd_en = 1'b0;
    chk("t2_rd_en_t1", chld_rd_en, 4'b0010);
    chk("t2_addr",     chld_addr, 12'h010);
    chk("t2_busy_t1",  lb_busy, 1);
    cyc();
    chk("t2_rd_en_t2", chld_rd_en, 4'b0000);
    chk("t2_busy_t2",  {lb_busy, lb_rd_valid}, 2'b10);
    cyc();
    chld_rd_valid = 4'b0010; chld_rd_data[32 +: 32] = 32'h1234_5678;
    chk("t2_busy_t3",  {lb_busy, lb_rd_valid}, 2'b10);
    cyc();
    chld_rd_valid = '0;
    chk("t2_rvalid",   {lb_busy, lb_rd_valid, lb_err}, 3'b110);
    chk("t2_rdata",    lb_rd_data, 32'h1234_5678);
    cyc();
    chk("t2_done",     {lb_busy, lb_rd_valid}, 0);
    chk("t2_hold",     lb_rd_data, 32'h1234_5678);

    // 3: read child 3, silent -> timeout at T17
    lb_rd_en = 1'b1; lb_addr = 16'h3000;
    cyc();
    lb_rd_en = 1'b0;
    chk("t3_rd_en",    chld_rd_en, 4'b1000);
    repeat (15) cyc();
    chk("t3_t16",      {lb_busy, lb_rd_valid}, 2'b10);
    cyc();
    chk("t3_t17",      {lb_rd_valid, lb_err}, 2'b11);
    chk("t3_data",     lb_rd_data, 32'hDEAD_BEEF);
    cyc();
    chk("t3_after",    {lb_busy, lb_rd_valid, lb_err}, 0);

    // 4: unmapped read and write
    lb_rd_en = 1'b1; lb_addr = 16'h7000;
    cyc();
    lb_rd_en = 1'b0;
    chk("t4_rd_resp",  {lb_rd_valid, lb_err, chld_rd_en}, 6'b110000);
    chk("t4_rd_data",  lb_rd_data, 32'hDEAD_BEEF);
    cyc();
    lb_wr_en = 1'b1; lb_addr = 16'h9000; lb_wr_data = 32'h0BAD_0BAD;
    cyc();
    lb_wr_en = 1'b0;
    chk("t4_wr_resp",  {lb_wr_valid, lb_err, chld_wr_en}, 6'b110000);
    cyc();

    // write beats simultaneous read
    lb_wr_en = 1'b1; lb_rd_en = 1'b1; lb_addr = 16'h0100; lb_wr_data = 32'h0000_0077;
    cyc();
    lb_wr_en = 1'b0; lb_rd_en = 1'b0;
    chk("both_wr",     {lb_wr_valid, chld_wr_en, chld_rd_en}, 9'b1_0001_0000);
    cyc();
    chk("both_idle",   {lb_busy, lb_rd_valid}, 0);

    // 5: other child's valid ignored
    lb_rd_en = 1'b1; lb_addr = 16'h0000;
    cyc();
    lb_rd_en = 1'b0;
    chld_rd_valid = 4'b0100; chld_rd_data[64 +: 32] = 32'hFFFF_FFFF;
    chk("t5_rd_en",    chld_rd_en, 4'b0001);
    cyc();
    chld_rd_valid = 4'b0001; chld_rd_data[0 +: 32] = 32'h0000_00AA;
    chk("t5_t2",       lb_rd_valid, 0);
    cyc();
    chld_rd_valid = '0;
    chk("t5_resp",     {lb_rd_valid, lb_err}, 2'b10);
    chk("t5_data",     lb_rd_data, 32'h0000_00AA);
    cyc();

    // 6: reset mid-read, late valid ignored, then a write
    lb_rd_en = 1'b1; lb_addr = 16'h1000;
    cyc();
    lb_rd_en = 1'b0;
    cyc();
    rst_ih = 1'b1;
    cyc();
    rst_ih = 1'b0;
    chk("t6_rst_outs", {lb_busy, lb_rd_valid, lb_wr_valid, lb_err, chld_wr_en, chld_rd_en}, 0);
    chk("t6_rst_data", {lb_rd_data, chld_addr}, 0);
    cyc();
    chld_rd_valid = 4'b0010; chld_rd_data[32 +: 32] = 32'hCAFE_F00D;
    cyc();
    chld_rd_valid = '0;
    chk("t6_no_resp",  {lb_rd_valid, lb_busy}, 0);
    lb_wr_en = 1'b1; lb_addr = 16'h1ABC; lb_wr_data = 32'h0000_0055;
    cyc();
    lb_wr_en = 1'b0;
    chk("t6_wr",       {lb_wr_valid, lb_err, chld_wr_en}, 6'b100010);
    chk("t6_wr_fld",   {chld_addr, chld_wr_data}, {12'hABC, 32'h0000_0055});
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
